// File: rtl/nn_ahb_mac_slave.sv
// AHB-Lite slave for the NN calculator: operand/control/result registers in front of a
// sequential signed shift-add multiply-accumulate engine; the data phase stalls while busy.
module nn_ahb_mac_slave #(
    parameter int unsigned OP_W  = 16,
    parameter int unsigned ACC_W = 32
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [4:0]  sel_in,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic        irq_done
);

    localparam int unsigned CNT_W  = $clog2(OP_W);
    localparam int unsigned PROD_W = 2 * OP_W;

    localparam logic [1:0] REG_INPUT  = 2'd0;
    localparam logic [1:0] REG_WEIGHT = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RESULT = 2'd3;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state;
    logic              ap_valid;
    logic              ap_write;
    logic [1:0]        ap_reg;
    logic [3:0]        sel_reg;
    logic              sel_onehot;
    logic [1:0]        sel_idx;
    logic [OP_W-1:0]   x_reg;
    logic [OP_W-1:0]   w_reg;
    logic [ACC_W-1:0]  acc;
    logic [15:0]       mac_cnt;
    logic [PROD_W-1:0] mcand;
    logic [PROD_W-1:0] prod;
    logic [OP_W-1:0]   mplier;
    logic              neg;
    logic [CNT_W-1:0]  cnt;
    logic              busy;
    logic              stall;
    logic              wr_fire;
    logic              rd_fire;
    logic [OP_W-1:0]   x_abs;
    logic [OP_W-1:0]   w_abs;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  prod_signed;
    logic              unused_bits;

    assign unused_bits = ^{sel_in[0], HTRANS[0], HWDATA[31:OP_W]};

    // Only a single selected register is a legal access; anything else is ignored quietly.
    assign sel_reg    = sel_in[4:1];
    assign sel_onehot = (sel_reg != 4'd0) && ((sel_reg & (sel_reg - 4'd1)) == 4'd0);

    always_comb begin
        sel_idx = REG_INPUT;
        case (sel_reg)
            4'b1000: sel_idx = REG_INPUT;
            4'b0100: sel_idx = REG_WEIGHT;
            4'b0010: sel_idx = REG_CTRL;
            4'b0001: sel_idx = REG_RESULT;
            default: sel_idx = REG_INPUT;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ap_valid <= 1'b0;
            ap_write <= 1'b0;
            ap_reg   <= REG_INPUT;
        end else if (HREADY) begin
            ap_valid <= HTRANS[1] & sel_onehot;
            ap_write <= HWRITE;
            ap_reg   <= sel_idx;
        end
    end

    assign busy      = (state != StIdle);
    assign stall     = ap_valid & busy & (ap_write | (ap_reg == REG_RESULT));
    assign HREADYOUT = ~stall;
    assign HRESP     = 1'b0;
    assign wr_fire   = ap_valid & ap_write & ~stall;
    assign rd_fire   = ap_valid & ~ap_write & ~stall;

    always_comb begin
        HRDATA = 32'd0;
        if (rd_fire) begin
            case (ap_reg)
                REG_INPUT:  HRDATA = {{(32 - OP_W){x_reg[OP_W-1]}}, x_reg};
                REG_WEIGHT: HRDATA = {{(32 - OP_W){w_reg[OP_W-1]}}, w_reg};
                REG_CTRL:   HRDATA = {mac_cnt, 14'd0, busy, 1'b0};
                default:    HRDATA = acc;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            x_reg <= '0;
            w_reg <= '0;
        end else if (wr_fire) begin
            if (ap_reg == REG_INPUT)  x_reg <= HWDATA[OP_W-1:0];
            if (ap_reg == REG_WEIGHT) w_reg <= HWDATA[OP_W-1:0];
        end
    end

    // Multiply magnitudes and reapply the sign at accumulate time; |-2^(OP_W-1)| still fits.
    assign x_abs       = x_reg[OP_W-1] ? (~x_reg + OP_W'(1)) : x_reg;
    assign w_abs       = w_reg[OP_W-1] ? (~w_reg + OP_W'(1)) : w_reg;
    assign prod_ext    = ACC_W'(prod);
    assign prod_signed = neg ? (~prod_ext + ACC_W'(1)) : prod_ext;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= StIdle;
            mcand    <= '0;
            mplier   <= '0;
            prod     <= '0;
            neg      <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            mac_cnt  <= '0;
            irq_done <= 1'b0;
        end else begin
            irq_done <= 1'b0;
            case (state)
                StIdle: begin
                    if (wr_fire && ap_reg == REG_CTRL) begin
                        if (HWDATA[1]) acc <= '0;
                        if (HWDATA[0]) begin
                            mcand  <= PROD_W'(x_abs);
                            mplier <= w_abs;
                            neg    <= x_reg[OP_W-1] ^ w_reg[OP_W-1];
                            prod   <= '0;
                            cnt    <= '0;
                            state  <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(OP_W - 1)) state <= StDone;
                end
                StDone: begin
                    acc      <= acc + prod_signed;
                    mac_cnt  <= mac_cnt + 16'd1;
                    irq_done <= 1'b1;
                    state    <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_ahb_mac_slave.sv
// Scoreboard bench for nn_ahb_mac_slave: reads push expected data from an arithmetic model,
// a negedge monitor pops and compares whenever a read data phase completes.
module tb_nn_ahb_mac_slave;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [4:0]  sel_in = 5'd0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic        HREADY;
    logic [31:0] HWDATA = 32'd0;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic        irq_done;

    assign HREADY = HREADYOUT;

    nn_ahb_mac_slave #(.OP_W(16), .ACC_W(32)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .sel_in    (sel_in),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HREADY    (HREADY),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .irq_done  (irq_done)
    );

    always #5 HCLK = ~HCLK;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    bit dp_active = 1'b0;
    bit dp_rd = 1'b0;

    // Reference model state
    logic [15:0] mx = 16'd0;
    logic [15:0] mw = 16'd0;
    logic [31:0] macc = 32'd0;
    logic [15:0] mcnt = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge HCLK) begin
        if (dp_active && dp_rd && HREADYOUT) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read_unexpected: got 0x%08h expected no read", HRDATA);
            end else begin
                check("read_data", HRDATA, exp_q.pop_front());
                check("hresp_okay", {31'd0, HRESP}, 32'd0);
            end
        end
    end

    function automatic logic [4:0] sel_of(input int idx);
        logic [4:0] s;
        s = 5'b10000;
        return s >> idx;
    endfunction

    function automatic logic [31:0] model_rd(input int idx);
        case (idx)
            0:       return {{16{mx[15]}}, mx};
            1:       return {{16{mw[15]}}, mw};
            2:       return {mcnt, 16'd0};
            default: return macc;
        endcase
    endfunction

    task automatic xfer(input bit wr, input logic [4:0] sel, input logic [1:0] htrans,
                        input logic [31:0] wdata, output int stalls);
        HTRANS = htrans;
        HWRITE = wr;
        sel_in = sel;
        @(posedge HCLK); #1;
        HTRANS    = 2'b00;
        sel_in    = 5'd0;
        HWRITE    = 1'b0;
        HWDATA    = wdata;
        dp_rd     = !wr;
        dp_active = 1'b1;
        stalls    = 0;
        while (!HREADYOUT && stalls < 200) begin
            @(posedge HCLK); #1;
            stalls++;
        end
        if (!HREADYOUT) begin
            checks++;
            errors++;
            $display("FAIL stall_timeout: got %0d stalled cycles expected completion", stalls);
        end
        @(posedge HCLK); #1;
        dp_active = 1'b0;
    endtask

    task automatic wr_reg(input int idx, input logic [31:0] d, output int stalls);
        xfer(1'b1, sel_of(idx), 2'b10, d, stalls);
        case (idx)
            0: mx = d[15:0];
            1: mw = d[15:0];
            2: begin
                if (d[1]) macc = 32'd0;
                if (d[0]) begin
                    macc = macc + 32'(int'($signed(mx)) * int'($signed(mw)));
                    mcnt = mcnt + 16'd1;
                end
            end
            default: ;
        endcase
    endtask

    task automatic rd_reg(input int idx, output int stalls);
        exp_q.push_back(model_rd(idx));
        xfer(1'b0, sel_of(idx), 2'b10, 32'd0, stalls);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int k;
        int irqs;
        logic [4:0] bad_sel[5];
        bad_sel[0] = 5'b11000;
        bad_sel[1] = 5'b00001;
        bad_sel[2] = 5'b00000;
        bad_sel[3] = 5'b10100;
        bad_sel[4] = 5'b01010;

        repeat (3) @(posedge HCLK);
        #1;
        check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check("rst_hrdata", HRDATA, 32'd0);
        check("rst_hresp", {31'd0, HRESP}, 32'd0);
        check("rst_irq", {31'd0, irq_done}, 32'd0);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;

        // 3 * -4 and the irq latency
        wr_reg(0, 32'd3, s);
        wr_reg(1, 32'h0000FFFC, s);
        wr_reg(2, 32'h3, s);
        k = 0;
        while (!irq_done && k < 40) begin
            @(posedge HCLK); #1;
            k++;
        end
        check("irq_latency", 32'(k), 32'd17);
        @(posedge HCLK); #1;
        check("irq_one_cycle", {31'd0, irq_done}, 32'd0);
        rd_reg(3, s);
        check("idle_result_no_stall", 32'(s), 32'd0);

        // RESULT read right after start stalls until the accumulate lands
        wr_reg(2, 32'h2, s);
        wr_reg(2, 32'h3, s);
        rd_reg(3, s);
        check("result_read_stall", 32'(s), 32'd16);

        // Most-negative operands and accumulator wrap
        wr_reg(0, 32'h8000, s);
        wr_reg(1, 32'h8000, s);
        wr_reg(2, 32'h3, s);
        rd_reg(3, s);
        for (int i = 0; i < 3; i++) begin
            wr_reg(2, 32'h1, s);
            rd_reg(3, s);
        end
        rd_reg(2, s);

        // Illegal selects and non-transfers leave registers alone without stalling
        xfer(1'b1, 5'b11000, 2'b10, 32'h1234, s);
        check("multi_sel_no_stall", 32'(s), 32'd0);
        xfer(1'b1, 5'b00001, 2'b10, 32'h1234, s);
        check("default_sel_no_stall", 32'(s), 32'd0);
        xfer(1'b1, sel_of(0), 2'b00, 32'h1234, s);
        xfer(1'b1, sel_of(2), 2'b01, 32'h3, s);
        irqs = 0;
        repeat (20) begin
            @(posedge HCLK); #1;
            if (irq_done) irqs++;
        end
        check("htrans_busy_no_start", 32'(irqs), 32'd0);
        rd_reg(0, s);
        rd_reg(1, s);
        exp_q.push_back(32'd0);
        xfer(1'b0, 5'b11000, 2'b10, 32'd0, s);
        exp_q.push_back(32'd0);
        xfer(1'b0, sel_of(3), 2'b00, 32'd0, s);

        // WEIGHT write during BUSY waits; the running product keeps the old weight
        wr_reg(0, 32'd5, s);
        wr_reg(1, 32'd7, s);
        wr_reg(2, 32'h1, s);
        wr_reg(1, 32'd9, s);
        check("busy_write_stall", 32'(s), 32'd16);
        rd_reg(1, s);
        rd_reg(3, s);

        // Reset while BUSY with a stalled write outstanding
        wr_reg(2, 32'h1, s);
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        sel_in = sel_of(1);
        @(posedge HCLK); #1;
        HTRANS = 2'b00;
        sel_in = 5'd0;
        HWRITE = 1'b0;
        HWDATA = 32'h55;
        check("stall_before_reset", {31'd0, HREADYOUT}, 32'd0);
        HRESETn = 1'b0;
        #1;
        check("reset_mid_busy_ready", {31'd0, HREADYOUT}, 32'd1);
        mx = 16'd0;
        mw = 16'd0;
        macc = 32'd0;
        mcnt = 16'd0;
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        irqs = 0;
        repeat (25) begin
            @(posedge HCLK); #1;
            if (irq_done) irqs++;
        end
        check("no_irq_after_reset", 32'(irqs), 32'd0);
        rd_reg(3, s);
        rd_reg(2, s);
        rd_reg(1, s);

        // Randomised traffic against the model
        for (int i = 0; i < 60; i++) begin
            int op;
            logic [31:0] d;
            op = $urandom_range(0, 9);
            d = $urandom;
            case (op)
                0, 1, 2, 3: wr_reg(op, d, s);
                4: rd_reg(0, s);
                5: rd_reg(1, s);
                6: rd_reg(3, s);
                7: begin
                    xfer(1'b1, bad_sel[$urandom_range(0, 4)], 2'b10, d, s);
                    check("rand_bad_sel_no_stall", 32'(s), 32'd0);
                end
                8: begin
                    exp_q.push_back(32'd0);
                    xfer(1'b0, bad_sel[$urandom_range(0, 4)], 2'b10, 32'd0, s);
                end
                default: xfer(1'b1, sel_of($urandom_range(0, 3)), 2'b00, d, s);
            endcase
        end
        rd_reg(3, s);
        rd_reg(2, s);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
